mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_pkg.sv | 11 +
 rtl/mem_lane.sv | 23 ++
 rtl/mem_ctrl.sv | 74 +++++++
 tb/tb_mem_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, controller states and access legality check.
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, READ, RMW_RD, WRITE, RESP} state_t;
  // Reserved size or an address not aligned to the access size
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane.sv
// mem_lane: little-endian lane extract/extend for loads and lane merge for stores.
module mem_lane import mem_pkg::*; (
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rd_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] merge_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);
  logic [31:0] sh, mask, data;
  always_comb begin
    sh = rd_i >> {off_i, 3'b000};
    load_o = size_i == SZ_BYTE ? {{24{sign_ext_i & sh[7]}}, sh[7:0]} :
             size_i == SZ_HALF ? {{16{sign_ext_i & sh[15]}}, sh[15:0]} : rd_i;
    mask = size_i == SZ_BYTE ? 32'h0000_00ff << {off_i, 3'b000} :
           size_i == SZ_HALF ? 32'h0000_ffff << {off_i[1], 4'b0000} : 32'hffff_ffff;
    data = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
           size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    store_o = (merge_i & ~mask) | (data & mask);
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port load/store controller with read-modify-write for sub-word stores.
module mem_ctrl import mem_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);
  state_t state_q, state_d;
  logic wr_q, sx_q, err_q;
  logic [1:0] size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, merge_q, rdata_q, load;
  mem_lane u_lane (
    .size_i(size_q), .sign_ext_i(sx_q), .off_i(addr_q[1:0]), .rd_i(mem_rd),
    .wdata_i(wdata_q), .merge_i(merge_q), .load_o(load), .store_o(mem_wd)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      sx_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        wr_q    <= wr;
        sx_q    <= sign_ext;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= bad_access(size, addr[1:0]);
      end
      if (state_q == RMW_RD) merge_q <= mem_rd;
      if (state_q == READ) rdata_q <= load;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = bad_access(size, addr[1:0]) ? RESP :
                                  !wr ? READ : size == SZ_WORD ? WRITE : RMW_RD;
      READ:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy   = state_q != IDLE;
  assign done   = state_q == RESP;
  assign err    = done & err_q;
  assign mem_we = state_q == WRITE && wr_q;
  assign mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
  assign rdata  = rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed table, corner sequences and random accesses against a byte-level memory model.
module tb_mem_ctrl;
  logic clk = 0, reset = 1, req = 0, wr = 0, sign_ext = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic busy, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;
  logic [31:0] mem [64];
  logic [31:0] rm [64];
  logic [31:0] r_rdata;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

  typedef struct {
    logic wr; logic [1:0] size; logic sx; logic [31:0] addr, wdata, rd;
    logic err; int lat; int we; logic [31:0] wd;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: byte-granular view of memory, legality by size-multiple alignment
  task automatic model(input logic w, input logic [1:0] s, input logic x, input logic [31:0] a, d,
                       output logic e, output int lat, output int wc, output logic [31:0] wd);
    int off, idx, n;
    logic [31:0] v, m;
    off = int'(a % 4);
    idx = int'((a / 4) % 64);
    n = 1 << s;
    e = (s == 2'd3) || (a % n != 0);
    lat = e ? 1 : (!w ? 2 : (n == 4 ? 2 : 3));
    wc = (!e && w) ? 1 : 0;
    wd = 0;
    if (!e && !w) begin
      v = rm[idx] >> (8 * off);
      m = (n == 4) ? 32'hffff_ffff : (32'h1 << (8 * n)) - 1;
      v = v & m;
      if (x && v[8*n-1]) v = v | ~m;
      r_rdata = v;
    end
    if (!e && w) begin
      for (int k = 0; k < n; k++) rm[idx][8*(off+k) +: 8] = d[8*k +: 8];
      wd = rm[idx];
    end
  endtask

  task automatic run(input logic w, input logic [1:0] s, input logic x, input logic [31:0] a, d,
                     output int lat, output logic e, output int wc, output logic [31:0] wd,
                     output logic [31:0] rd);
    @(negedge clk);
    wr = w; size = s; sign_ext = x; addr = a; wdata = d; req = 1;
    @(negedge clk);
    req = 0; lat = 0; e = 0; wc = 0; wd = 0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    for (int n = 1; n <= 10; n++) begin
      if (mem_we) begin wc++; wd = mem_wd; end
      if (done) begin lat = n; e = err; break; end
      @(negedge clk);
    end
    rd = rdata;
  endtask

  task automatic compare(input string tag, input int lat, e_lat, input logic e, e_e,
                         input int wc, e_wc, input logic [31:0] wd, e_wd, rd, e_rd);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, e_e});
    chk({tag, "_we_cycles"}, wc, e_wc);
    if (e_wc > 0) chk({tag, "_mem_wd"}, wd, e_wd);
    chk({tag, "_rdata"}, rd, e_rd);
  endtask

  initial begin
    int lat, wc, m_lat, m_wc, dn, wes;
    logic e, m_e;
    logic [31:0] wd, rd, m_wd;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0101_0101 * i;
      rm[i] = 32'h0101_0101 * i;
    end
    mem[16] = 32'h8899_AABB;
    rm[16] = 32'h8899_AABB;
    r_rdata = 0;
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_mem_a", mem_a, 32'd0);
    chk("reset_mem_wd", mem_wd, 32'd0);
    repeat (2) @(negedge clk);
    reset = 0;

    tbl[0]  = '{0, 2'd0, 1, 32'h43, 32'h0,        32'hFFFF_FF88, 0, 2, 0, 32'h0};
    tbl[1]  = '{0, 2'd1, 0, 32'h42, 32'h0,        32'h0000_8899, 0, 2, 0, 32'h0};
    tbl[2]  = '{0, 2'd0, 1, 32'h40, 32'h0,        32'hFFFF_FFBB, 0, 2, 0, 32'h0};
    tbl[3]  = '{0, 2'd1, 1, 32'h40, 32'h0,        32'hFFFF_AABB, 0, 2, 0, 32'h0};
    tbl[4]  = '{1, 2'd0, 0, 32'h41, 32'h1234_565A, 32'hFFFF_AABB, 0, 3, 1, 32'h8899_5ABB};
    tbl[5]  = '{0, 2'd2, 0, 32'h40, 32'h0,        32'h8899_5ABB, 0, 2, 0, 32'h0};
    tbl[6]  = '{0, 2'd2, 0, 32'h46, 32'h0,        32'h8899_5ABB, 1, 1, 0, 32'h0};
    tbl[7]  = '{1, 2'd1, 0, 32'h41, 32'h0000_FFFF, 32'h8899_5ABB, 1, 1, 0, 32'h0};
    tbl[8]  = '{0, 2'd3, 0, 32'h40, 32'h0,        32'h8899_5ABB, 1, 1, 0, 32'h0};
    tbl[9]  = '{1, 2'd2, 0, 32'h44, 32'hDEAD_BEEF, 32'h8899_5ABB, 0, 2, 1, 32'hDEAD_BEEF};
    tbl[10] = '{1, 2'd1, 0, 32'h42, 32'h1234_CAFE, 32'h8899_5ABB, 0, 3, 1, 32'hCAFE_5ABB};
    tbl[11] = '{0, 2'd2, 0, 32'h40, 32'h0,        32'hCAFE_5ABB, 0, 2, 0, 32'h0};
    tbl[12] = '{0, 2'd0, 0, 32'h45, 32'h0,        32'h0000_00BE, 0, 2, 0, 32'h0};
    tbl[13] = '{0, 2'd1, 1, 32'h46, 32'h0,        32'hFFFF_DEAD, 0, 2, 0, 32'h0};
    for (int i = 0; i < 14; i++) begin
      model(tbl[i].wr, tbl[i].size, tbl[i].sx, tbl[i].addr, tbl[i].wdata, m_e, m_lat, m_wc, m_wd);
      run(tbl[i].wr, tbl[i].size, tbl[i].sx, tbl[i].addr, tbl[i].wdata, lat, e, wc, wd, rd);
      compare($sformatf("vec%0d", i), lat, tbl[i].lat, e, tbl[i].err, wc, tbl[i].we,
              wd, tbl[i].wd, rd, tbl[i].rd);
    end

    // Reset in WRITE of a word store: write must be suppressed and access dropped
    @(negedge clk);
    wr = 1; size = 2'd2; sign_ext = 0; addr = 32'h48; wdata = 32'h1111_1111; req = 1;
    @(negedge clk);
    req = 0;
    chk("rst_write_we_before", {31'd0, mem_we}, 32'd1);
    reset = 1;
    #1;
    chk("rst_write_we_dropped", {31'd0, mem_we}, 32'd0);
    chk("rst_write_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 0;
    r_rdata = 0;
    dn = 0; wes = 0;
    repeat (4) begin @(negedge clk); dn += int'(done); wes += int'(mem_we); end
    chk("rst_write_no_done", dn, 0);
    chk("rst_write_no_we", wes, 0);
    chk("rst_write_mem_kept", mem[18], rm[18]);
    chk("rst_write_rdata", rdata, 32'd0);
    model(0, 2'd2, 0, 32'h48, 32'h0, m_e, m_lat, m_wc, m_wd);
    run(0, 2'd2, 0, 32'h48, 32'h0, lat, e, wc, wd, rd);
    compare("post_reset", lat, m_lat, e, m_e, wc, m_wc, wd, m_wd, rd, r_rdata);

    // req held high with a different store while busy must be ignored
    model(0, 2'd2, 0, 32'h40, 32'h0, m_e, m_lat, m_wc, m_wd);
    @(negedge clk);
    wr = 0; size = 2'd2; sign_ext = 0; addr = 32'h40; wdata = 32'h0; req = 1;
    @(negedge clk);
    wr = 1; wdata = 32'h7777_7777;
    lat = 0; wes = 0;
    for (int n = 1; n <= 10; n++) begin
      wes += int'(mem_we);
      if (done) begin lat = n; req = 0; break; end
      @(negedge clk);
    end
    chk("busy_req_lat", lat, m_lat);
    chk("busy_req_rdata", rdata, r_rdata);
    dn = 0;
    repeat (5) begin @(negedge clk); dn += int'(done); wes += int'(mem_we); end
    chk("busy_req_extra_done", dn, 0);
    chk("busy_req_no_we", wes, 0);
    chk("busy_req_mem_kept", mem[16], rm[16]);

    for (int i = 0; i < 300; i++) begin
      logic w, x;
      logic [1:0] s;
      logic [31:0] a, d;
      w = 1'($urandom_range(0, 1));
      x = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 255);
      d = $urandom;
      model(w, s, x, a, d, m_e, m_lat, m_wc, m_wd);
      run(w, s, x, a, d, lat, e, wc, wd, rd);
      compare($sformatf("rnd%0d", i), lat, m_lat, e, m_e, wc, m_wc, wd, m_wd, rd, r_rdata);
    end
    @(negedge clk);
    for (int i = 0; i < 64; i++) chk($sformatf("final_mem%0d", i), mem[i], rm[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
